// File: rtl/pending_encoder_32_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pending_encoder_32_if
// Handshake/bus bundle between the pending encoder and its producer/consumer.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface pending_encoder_32_if #(
  parameter int CNT_W = 8
);
  logic [31:0]      req;
  logic             clr_all;
  logic             out_ack;
  logic             out_valid;
  logic [4:0]       out_index;
  logic [31:0]      pending;
  logic [CNT_W-1:0] coal_cnt;

  modport master (
    output req, clr_all, out_ack,
    input  out_valid, out_index, pending, coal_cnt
  );

  modport slave (
    input  req, clr_all, out_ack,
    output out_valid, out_index, pending, coal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pending_encoder_32.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pending_encoder_32
// Sticky 32-bit pending vector emitted one 5-bit index at a time over
// valid/ack. Optional macro ROUND_ROBIN_EN selects round-robin arbitration.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module pending_encoder_32 #(
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  pending_encoder_32_if.slave  bus
);

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             valid;
  logic [4:0]       index;
  logic [31:0]      pend;
  logic [CNT_W-1:0] coal;
`ifdef ROUND_ROBIN_EN
  logic [4:0]       rr_ptr;
`endif

  logic [31:0] index_onehot;
  logic        ack_fire;
  logic [31:0] pend_kept;
  logic [31:0] pending_nxt;
  logic [31:0] src;
  logic        coal_hit;
  logic        sel_found;
  logic [4:0]  sel_idx;

  assign index_onehot = 32'd1 << index;
  assign ack_fire     = valid & bus.out_ack;
  assign pend_kept    = pend & ~(ack_fire ? index_onehot : 32'd0);
  // Set dominates clear: a req on the acked bit keeps it pending.
  assign pending_nxt  = pend_kept | bus.req;
  assign src          = pending_nxt & ~((valid & ~bus.out_ack) ? index_onehot : 32'd0);
  assign coal_hit     = |(bus.req & pend_kept);

`ifdef ROUND_ROBIN_EN
  always_comb begin
    logic [4:0] pos;
    sel_found = 1'b0;
    sel_idx   = 5'd0;
    pos       = 5'd0;
    for (int k = 0; k < 32; k++) begin
      pos = rr_ptr + 5'd1 + k[4:0];
      if (!sel_found && src[pos]) begin
        sel_found = 1'b1;
        sel_idx   = pos;
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 5'd0;
    for (int k = 0; k < 32; k++) begin
      if (!sel_found && src[k]) begin
        sel_found = 1'b1;
        sel_idx   = k[4:0];
      end
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      valid  <= 1'b0;
      index  <= 5'd0;
      pend   <= 32'd0;
      coal   <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr <= 5'd31;
`endif
    end else if (bus.clr_all) begin
      state <= EMPTY;
      valid <= 1'b0;
      pend  <= 32'd0;
    end else begin
      pend <= pending_nxt;
      if (coal_hit && (coal != CNT_MAX)) begin
        coal <= coal + CNT_ONE;
      end
      case (state)
        EMPTY: begin
          if (sel_found) begin
            state  <= PRESENT;
            valid  <= 1'b1;
            index  <= sel_idx;
`ifdef ROUND_ROBIN_EN
            rr_ptr <= sel_idx;
`endif
          end
        end
        PRESENT: begin
          // Index is held stable until the consumer acks it.
          if (bus.out_ack) begin
            if (sel_found) begin
              valid  <= 1'b1;
              index  <= sel_idx;
`ifdef ROUND_ROBIN_EN
              rr_ptr <= sel_idx;
`endif
            end else begin
              state <= EMPTY;
              valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_index = index;
  assign bus.pending   = pend;
  assign bus.coal_cnt  = coal;

endmodule
`default_nettype wire

// File: tb/tb_pending_encoder_32.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_pending_encoder_32
// Directed and random stimulus against a behavioural model of the encoder.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_pending_encoder_32;

  localparam int CNT_W   = 8;
  localparam int CNT_LIM = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pending_encoder_32_if #(.CNT_W(CNT_W)) bus ();

  pending_encoder_32 #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pend;
  bit          m_valid;
  int          m_idx;
  int          m_coal;
  int          m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},   32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".index"},   32'(bus.out_index), 32'(m_idx));
    chk({tag, ".pending"}, bus.pending,        m_pend);
    chk({tag, ".coal"},    32'(bus.coal_cnt),  32'(m_coal));
  endtask

  task automatic model_reset();
    m_pend  = 32'd0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_coal  = 0;
    m_rr    = 31;
  endtask

  // One clock of the encoder's behaviour, expressed directly from its rules.
  task automatic model_step(input logic [31:0] r, input logic a, input logic c);
    logic [31:0] newp;
    bit acked, hit, found, still;
    int start, j;
    if (c) begin
      m_pend  = 32'd0;
      m_valid = 1'b0;
      return;
    end
    acked = m_valid && a;
    hit   = 1'b0;
    newp  = 32'd0;
    for (int i = 0; i < 32; i++) begin
      still = m_pend[i] && !(acked && (i == m_idx));
      if (r[i] && still) hit = 1'b1;
      newp[i] = still || r[i];
    end
    if (hit && m_coal < CNT_LIM) m_coal++;
    if (!m_valid || acked) begin
`ifdef ROUND_ROBIN_EN
      start = (m_rr + 1) % 32;
`else
      start = 0;
`endif
      found = 1'b0;
      for (int k = 0; k < 32; k++) begin
        j = (start + k) % 32;
        if (!found && newp[j]) begin
          found = 1'b1;
          m_idx = j;
          m_rr  = j;
        end
      end
      m_valid = found;
    end
    m_pend = newp;
  endtask

  task automatic step(input logic [31:0] r, input logic a, input logic c, input string tag);
    bus.req     = r;
    bus.out_ack = a;
    bus.clr_all = c;
    model_step(r, a, c);
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_model({tag, ".async"});
    #2;
    reset       = 1'b0;
    bus.req     = 32'd0;
    bus.out_ack = 1'b0;
    bus.clr_all = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_idx;
    bus.req     = 32'd0;
    bus.out_ack = 1'b0;
    bus.clr_all = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_model("reset");

    // Single request, then ack.
    step(32'h0000_0001, 1'b0, 1'b0, "t1.load");
    chk("t1.index0", 32'(bus.out_index), 32'd0);
    chk("t1.pend1",  bus.pending,        32'd1);
    step(32'd0, 1'b1, 1'b0, "t1.ack");
    chk("t1.empty",  32'(bus.out_valid), 32'd0);

    // Three requests drained back-to-back.
    do_reset("t2");
    step(32'h8000_0011, 1'b0, 1'b0, "t2.load");
    chk("t2.first", 32'(bus.out_index), 32'd0);
    step(32'd0, 1'b1, 1'b0, "t2.a1");
    chk("t2.second", 32'(bus.out_index), 32'd4);
    step(32'd0, 1'b1, 1'b0, "t2.a2");
    chk("t2.third", 32'(bus.out_index), 32'd31);
    step(32'd0, 1'b1, 1'b0, "t2.a3");
    chk("t2.drained", 32'(bus.out_valid), 32'd0);

    // Re-request on the bit being acked.
    do_reset("t3");
    step(32'h0000_0020, 1'b0, 1'b0, "t3.load");
    step(32'h0000_0020, 1'b1, 1'b0, "t3.reack");
    chk("t3.pend5",  32'(bus.pending[5]), 32'd1);
    chk("t3.index5", 32'(bus.out_index),  32'd5);
    chk("t3.coal",   32'(bus.coal_cnt),   32'd0);

    // Coalescing counter saturation.
    do_reset("t4");
    step(32'h0000_0004, 1'b0, 1'b0, "t4.load");
    for (int n = 0; n < 300; n++) step(32'h0000_0004, 1'b0, 1'b0, "t4.hold");
    chk("t4.sat",   32'(bus.coal_cnt),  32'd255);
    chk("t4.index", 32'(bus.out_index), 32'd2);

    // Flush beats a simultaneous request; reset mid-stream.
    do_reset("t5");
    step(32'h0000_00FF, 1'b0, 1'b0, "t5.load");
    chk("t5.pendFF", bus.pending, 32'h0000_00FF);
    step(32'h0000_0100, 1'b0, 1'b1, "t5.clr");
    chk("t5.flushp", bus.pending,        32'd0);
    chk("t5.flushv", 32'(bus.out_valid), 32'd0);
    step(32'h0000_0F0F, 1'b0, 1'b0, "t5.refill");
    step(32'd0, 1'b1, 1'b0, "t5.mid");
    do_reset("t5.rst");
    chk("t5.rstpend", bus.pending, 32'd0);

    // Held pair of requests with continuous ack.
    do_reset("t6");
    step(32'h0000_0003, 1'b0, 1'b0, "t6.load");
    for (int n = 0; n < 4; n++) begin
      step(32'h0000_0003, 1'b1, 1'b0, "t6.run");
`ifdef ROUND_ROBIN_EN
      exp_idx = (n % 2 == 0) ? 1 : 0;
`else
      exp_idx = 0;
`endif
      chk("t6.pattern", 32'(bus.out_index), 32'(exp_idx));
    end

    // Random traffic.
    do_reset("rnd");
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic a, c;
      r = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) r = 32'd0;
      a = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 40) == 0);
      step(r, a, c, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
